// File: rtl/alu_exec_unit.sv
// ALU control and execute stage for the LEGv8 datapath: decodes ALUOp/opcode, runs
// single-cycle ops with latency 1 and an iterative shift-add MUL, valid/ready on both sides.
module alu_exec_unit #(
    parameter int unsigned WIDTH  = 64,
    parameter bit          MUL_EN = 1'b1,
    parameter int unsigned SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       op_code,
    output logic             illegal
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOrr  = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpEor  = 4'b0011;
    localparam logic [3:0] OpLsl  = 4'b0100;
    localparam logic [3:0] OpLsr  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpPass = 4'b0111;
    localparam logic [3:0] OpMul  = 4'b1000;
    localparam logic [3:0] OpIll  = 4'b1111;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       opc_q, opc_d;
    logic             ill_q, ill_d;

    logic [3:0]       dec_code;
    logic             dec_ill;
    logic [WIDTH-1:0] alu_res;
    logic             accept;

    // ALUOp bit 0 wins over bit 1, so 11 decodes as PASS_B.
    always_comb begin
        dec_code = OpAdd;
        dec_ill  = 1'b0;
        if (alu_op[0]) begin
            dec_code = OpPass;
        end else if (alu_op[1]) begin
            case (opcode)
                11'b10001011000: dec_code = OpAdd;
                11'b11001011000: dec_code = OpSub;
                11'b10001010000: dec_code = OpAnd;
                11'b10101010000: dec_code = OpOrr;
                11'b11001010000: dec_code = OpEor;
                11'b11010011011: dec_code = OpLsl;
                11'b11010011010: dec_code = OpLsr;
                11'b10011011000: begin
                    dec_code = MUL_EN ? OpMul : OpIll;
                    dec_ill  = !MUL_EN;
                end
                default: begin
                    dec_code = OpIll;
                    dec_ill  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        case (dec_code)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a + ~op_b + WIDTH'(1);
            OpAnd:   alu_res = op_a & op_b;
            OpOrr:   alu_res = op_a | op_b;
            OpEor:   alu_res = op_a ^ op_b;
            OpLsl:   alu_res = op_a << op_b[SHW-1:0];
            OpLsr:   alu_res = op_a >> op_b[SHW-1:0];
            OpPass:  alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        opc_d     = opc_q;
        ill_d     = ill_q;
        in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        out_valid = (state_q == StDone);
        accept    = in_valid && in_ready;

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    opc_d = dec_code;
                    ill_d = dec_ill;
                    if (dec_code == OpMul) begin
                        state_d = StExec;
                        res_d   = '0;
                        a_d     = op_a;
                        b_d     = op_b;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDone;
                        res_d   = alu_res;
                    end
                end else if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StExec: begin
                // res_q doubles as the partial-product accumulator.
                res_d = res_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            opc_q   <= 4'b0000;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            ill_q   <= ill_d;
        end
    end

    assign result  = res_q;
    assign zero    = (res_q == '0);
    assign op_code = opc_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops against a
// behavioural model; a second instance with MUL_EN=0 covers the illegal MUL path.
module tb_alu_exec_unit;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_valid2;
    logic         in_ready, in_ready2;
    logic [1:0]   alu_op;
    logic [10:0]  opcode;
    logic [W-1:0] op_a, op_b;
    logic         out_valid, out_valid2;
    logic         out_ready, out_ready2;
    logic [W-1:0] result, result2;
    logic         zero, zero2;
    logic [3:0]   op_code, op_code2;
    logic         illegal, illegal2;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic         ill;
        logic [3:0]   code;
        logic [W-1:0] res;
    } exp_t;

    alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .opcode(opcode), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .op_code(op_code), .illegal(illegal)
    );

    alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .alu_op(alu_op), .opcode(opcode), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .zero(zero2),
        .op_code(op_code2), .illegal(illegal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] aop, input logic [10:0] opc,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit mul_en);
        exp_t e;
        e.ill  = 1'b0;
        e.code = 4'b0010;
        e.res  = a + b;
        if (aop[0]) begin
            e.code = 4'b0111;
            e.res  = b;
        end else if (aop[1]) begin
            case (opc)
                11'b10001011000: begin e.code = 4'b0010; e.res = a + b;         end
                11'b11001011000: begin e.code = 4'b0110; e.res = a - b;         end
                11'b10001010000: begin e.code = 4'b0000; e.res = a & b;         end
                11'b10101010000: begin e.code = 4'b0001; e.res = a | b;         end
                11'b11001010000: begin e.code = 4'b0011; e.res = a ^ b;         end
                11'b11010011011: begin e.code = 4'b0100; e.res = a << b[5:0];   end
                11'b11010011010: begin e.code = 4'b0101; e.res = a >> b[5:0];   end
                11'b10011011000: begin
                    if (mul_en) begin e.code = 4'b1000; e.res = a * b; end
                    else begin e.code = 4'b1111; e.res = '0; e.ill = 1'b1; end
                end
                default: begin e.code = 4'b1111; e.res = '0; e.ill = 1'b1; end
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the DUT in DONE with out_ready=1 at a negedge.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [10:0] opc,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard;
        int   lat;
        int   busy;
        bit   is_mul;
        e      = model(aop, opc, a, b, 1'b1);
        is_mul = (e.code == 4'b1000);
        alu_op = aop; opcode = opc; op_a = a; op_b = b;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("%s_accept", tag), W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s_latency", tag), W'(lat), is_mul ? W'(W + 1) : W'(1));
        check($sformatf("%s_busy", tag), W'(busy), is_mul ? W'(W) : W'(0));
        check($sformatf("%s_result", tag), result, e.res);
        check($sformatf("%s_zero", tag), W'(zero), W'(e.res == '0));
        check($sformatf("%s_opcode", tag), W'(op_code), W'(e.code));
        check($sformatf("%s_illegal", tag), W'(illegal), W'(e.ill));
    endtask

    logic [10:0] opc_tab [8];

    initial begin
        opc_tab[0] = 11'b10001011000; opc_tab[1] = 11'b11001011000;
        opc_tab[2] = 11'b10001010000; opc_tab[3] = 11'b10101010000;
        opc_tab[4] = 11'b11001010000; opc_tab[5] = 11'b11010011011;
        opc_tab[6] = 11'b11010011010; opc_tab[7] = 11'b10011011000;

        rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        alu_op = 2'b00; opcode = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);

        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_result", result, W'(0));
        check("rst_zero", W'(zero), W'(1));
        check("rst_op_code", W'(op_code), W'(0));
        check("rst_illegal", W'(illegal), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_nomul_out_valid", W'(out_valid2), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sub_10_3", 2'b10, 11'b11001011000, 64'd10, 64'd3);
        check("sub_10_3_const", result, 64'd7);
        run_op("pass01", 2'b01, 11'b00000000000, 64'hDEAD, 64'd0);
        check("pass01_zero_const", W'(zero), W'(1));
        run_op("pass11", 2'b11, 11'b11111111111, 64'hBEEF, 64'd0);
        run_op("mul_ff_2", 2'b10, 11'b10011011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        check("mul_ff_2_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("lsl63", 2'b10, 11'b11010011011, 64'd1, 64'd63);
        check("lsl63_const", result, 64'h8000_0000_0000_0000);
        run_op("lsr63", 2'b10, 11'b11010011010, 64'h8000_0000_0000_0000, 64'd63);
        run_op("sub_wrap", 2'b10, 11'b11001011000, 64'd0, 64'd1);
        check("sub_wrap_const", result, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("lsl0", 2'b10, 11'b11010011011, 64'h1234, 64'd64);
        run_op("illegal_opc", 2'b10, 11'b00000000001, 64'd5, 64'd6);

        // MUL_EN=0 instance: MUL is illegal and completes with latency 1.
        alu_op = 2'b10; opcode = 11'b10011011000; op_a = 64'hFF; op_b = 64'd2;
        in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        check("nomul_out_valid", W'(out_valid2), W'(1));
        check("nomul_illegal", W'(illegal2), W'(1));
        check("nomul_result", result2, W'(0));
        check("nomul_op_code", W'(op_code2), W'(4'b1111));

        // Back-to-back ADD then AND.
        alu_op = 2'b10; opcode = opc_tab[0]; op_a = 64'd1; op_b = 64'd2;
        out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_valid", W'(out_valid), W'(1));
        check("b2b_first_result", result, 64'd3);
        opcode = opc_tab[2]; op_a = 64'hF0; op_b = 64'h3C;
        @(negedge clk);
        check("b2b_second_valid", W'(out_valid), W'(1));
        check("b2b_second_result", result, 64'h30);
        check("b2b_second_opcode", W'(op_code), W'(4'b0000));
        in_valid = 1'b0;
        @(negedge clk);

        // Downstream stall holds the result and blocks the pending request.
        opcode = opc_tab[0]; op_a = 64'd1; op_b = 64'd2; in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        opcode = opc_tab[2]; op_a = 64'hF0; op_b = 64'h3C;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_result", i), result, 64'd3);
            check($sformatf("stall%0d_in_ready", i), W'(in_ready), W'(0));
            check($sformatf("stall%0d_out_valid", i), W'(out_valid), W'(1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        check("stall_after_result", result, 64'h30);
        in_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a MUL.
        opcode = opc_tab[7]; op_a = 64'h1234_5678; op_b = 64'h9ABC; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("midmul_busy", W'(in_ready), W'(0));
        rst_n = 1'b0;
        #1;
        check("midmul_rst_out_valid", W'(out_valid), W'(0));
        check("midmul_rst_in_ready", W'(in_ready), W'(1));
        check("midmul_rst_result", result, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midmul_no_emit", W'(out_valid), W'(0));
        end
        run_op("post_rst_add", 2'b00, 11'b0, 64'd5, 64'd5);
        check("post_rst_add_const", result, 64'd10);

        // Randomized ops against the model.
        for (int i = 0; i < 30; i++) begin
            logic [1:0]   aop;
            logic [10:0]  opc;
            logic [W-1:0] a, b;
            aop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            opc = ($urandom_range(0, 7) == 0) ? 11'($urandom) : opc_tab[$urandom_range(0, 7)];
            a   = {$urandom, $urandom};
            b   = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : W'($urandom_range(0, 70));
            run_op($sformatf("rnd%0d", i), aop, opc, a, b);
        end

        in_valid = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
